inverse_interpolate: RTL and testbench
======================================

# inverse_interpolate

Computes the inverse of a piecewise-linear segment: given a target ordinate `y` and segment endpoints (x0,y0),(x1,y1), produces the abscissa x = x0 + (y−y0)·(x1−x0)/(y1−y0). It is the counterpart of the forward `linearinterpolate` stage and runs on the same 14-bit unsigned datapath. Typical use is mapping a measured value back to a setpoint through a calibration segment. The block uses a start/done handshake, a registered multiply and an iterative restoring divider.

## Interface
- `W`, 14: data width; all coordinates are unsigned `W`-bit.
- `clk`  in  1  rising-edge clock; the block has one clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `y`  in  W  target ordinate.
- `x0`, `y0`  in  W each  segment start point.
- `x1`, `y1`  in  W each  segment end point.
- `x`  out  W  result, registered, held until the next result.
- `done`  out  1  one-cycle pulse when `x`/`sat`/`err` are updated.
- `busy`  out  1  high from the start-accept edge until the edge that raises `done`.
- `sat`  out  1  `y` was outside the segment; result clamped.
- `err`  out  1  degenerate segment; result forced to `x0`.

## Operation
- States: IDLE, SETUP, MUL, DIV, FIN.
- IDLE: on `start`=1, capture all inputs into internal registers, set `busy`=1, go to SETUP. Inputs may change after capture.
- SETUP: compute `dx`=x1−x0 and `dy`=|y1−y0|. Direction is ascending if y1>y0, descending otherwise. Compute `dyin`=|y−y0| in the segment direction.
  - If y1==y0 or x1<x0: result=x0, `err`=1, `sat`=0, go to FIN.
  - Else if `y` lies outside the closed range between y0 and y1: result is x0 when `y` is beyond the y0 side, x1 when beyond the y1 side; `sat`=1, `err`=0; go to FIN.
  - Else: `err`=`sat`=0, go to MUL.
- MUL: register the 2W-bit product `num`=dyin·dx, go to DIV.
- DIV: restoring division `num`/`dy`, one quotient bit per cycle, MSB first, W iterations. The quotient is guaranteed < 2^W because dyin ≤ dy. After the last iteration, go to FIN.
- FIN: `x` = x0 + quotient (truncated toward zero, never exceeds x1); pulse `done`; clear `busy`; return to IDLE.
- `start` while `busy`=1 is ignored; it is neither queued nor does it disturb the operation in progress.
- Arithmetic is unsigned throughout: a 2W-bit product, a W+1-bit partial remainder, and no overflow possible on `x`.
- `x`, `sat` and `err` change only on the FIN edge and otherwise hold their values.

## Timing
- Reset state: IDLE, `x`=0, `done`=0, `busy`=0, `sat`=0, `err`=0, all internal registers cleared.
- `rst` asserted mid-operation aborts immediately. No `done` is produced; outputs return to their reset values.
- Edge E0 samples `start`. Normal path: SETUP at E1, MUL at E2, DIV at E3..E(2+W), FIN at E(3+W). `done`=1 during the cycle after edge E(3+W), which is 17 clocks after E0 for W=14.
- Early-exit path (err/sat): SETUP at E1, FIN at E2. `done`=1 during the cycle after E2.
- `busy` falls on the same edge that raises `done`. A `start` held high through the `done` cycle is accepted on the next edge, giving back-to-back operation with one IDLE cycle.
- `done` is high for exactly one cycle per accepted `start`.

## Test plan
- Ascending: x0=100, y0=200, x1=300, y1=600, y=400 -> `x`=200, `sat`=0, `err`=0, `done` 17 cycles after start.
- Descending with truncation: x0=100, y0=600, x1=300, y1=200, y=500 -> `x`=150. Also x0=0, y0=0, x1=10, y1=3, y=1 -> `x`=3.
- Clamp: first segment with y=700 -> `x`=300, `sat`=1, `done` 2 cycles after start. With y=150 -> `x`=100, `sat`=1.
- Degenerate: y0=y1=50, x0=7 -> `x`=7, `err`=1. Also x0=20, x1=10 -> `err`=1.
- Full scale: x0=0, y0=0, x1=16383, y1=16383, y=16383 -> `x`=16383. With y=1 -> `x`=1.
- Control: pulse `start` every cycle during an operation -> exactly one `done`, with the result from the first capture. Assert `rst` at cycle 8 of DIV -> no `done` and all outputs zero; the next `start` then completes normally.

Source files
------------

// File: rtl/inverse_interpolate.sv
`timescale 1ns/1ps
// inverse_interpolate: x = x0 + (y - y0) * (x1 - x0) / (y1 - y0) over one linear segment.
// Inputs are captured on start. SETUP classifies the request; the normal path
// goes through a registered multiply and a W-cycle restoring divide. The
// degenerate and clamp paths jump straight from SETUP to FIN.
module inverse_interpolate #(
    parameter int unsigned W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] y,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    output logic [W-1:0] x,
    output logic         done,
    output logic         busy,
    output logic         sat,
    output logic         err
);

    localparam int unsigned CW = $clog2(W) + 1;

    typedef enum logic [2:0] {StIdle, StSetup, StMul, StDiv, StFin} state_t;

    state_t         r_state;
    logic [W-1:0]   r_y, r_x0, r_y0, r_x1, r_y1;
    logic [W-1:0]   r_dx, r_dy, r_dyin;
    // High half holds the partial remainder; low half shifts dividend bits out
    // and quotient bits in.
    logic [2*W-1:0] r_num;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_res;
    logic           r_pend_sat, r_pend_err;
    logic [W-1:0]   r_x;
    logic           r_done, r_busy, r_sat, r_err;

    logic           w_asc;
    logic [W-1:0]   w_dx, w_dy, w_dyin;
    logic           w_degen, w_beyond_y0, w_beyond_y1;
    logic [2*W-1:0] w_prod;
    logic [W:0]     w_trial, w_diff;
    logic           w_ge;
    logic [W-1:0]   w_rem_nx;
    logic [W-1:0]   w_quo_nx;

    // Segment classification and deltas from the captured operands.
    always_comb begin
        w_asc       = r_y1 > r_y0;
        w_dx        = r_x1 - r_x0;
        w_dy        = w_asc ? (r_y1 - r_y0) : (r_y0 - r_y1);
        w_dyin      = w_asc ? (r_y - r_y0) : (r_y0 - r_y);
        w_degen     = (r_y1 == r_y0) || (r_x1 < r_x0);
        w_beyond_y0 = w_asc ? (r_y < r_y0) : (r_y > r_y0);
        w_beyond_y1 = w_asc ? (r_y > r_y1) : (r_y < r_y1);
    end

    // Product and one restoring-division step.
    always_comb begin
        w_prod   = (2*W)'(r_dyin) * (2*W)'(r_dx);
        w_trial  = {r_num[2*W-1:W], r_num[W-1]};
        w_diff   = w_trial - {1'b0, r_dy};
        w_ge     = w_trial >= {1'b0, r_dy};
        // When the trial fails it is below dy, so its top bit is already zero.
        w_rem_nx = w_ge ? w_diff[W-1:0] : w_trial[W-1:0];
        w_quo_nx = {r_num[W-2:0], w_ge};
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_y        <= '0;
            r_x0       <= '0;
            r_y0       <= '0;
            r_x1       <= '0;
            r_y1       <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_dyin     <= '0;
            r_num      <= '0;
            r_cnt      <= '0;
            r_res      <= '0;
            r_pend_sat <= 1'b0;
            r_pend_err <= 1'b0;
            r_x        <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_sat      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_y     <= y;
                        r_x0    <= x0;
                        r_y0    <= y0;
                        r_x1    <= x1;
                        r_y1    <= y1;
                        r_busy  <= 1'b1;
                        r_state <= StSetup;
                    end
                end
                StSetup: begin
                    r_dx   <= w_dx;
                    r_dy   <= w_dy;
                    r_dyin <= w_dyin;
                    if (w_degen) begin
                        r_res      <= r_x0;
                        r_pend_err <= 1'b1;
                        r_pend_sat <= 1'b0;
                        r_state    <= StFin;
                    end else if (w_beyond_y0 || w_beyond_y1) begin
                        r_res      <= w_beyond_y0 ? r_x0 : r_x1;
                        r_pend_err <= 1'b0;
                        r_pend_sat <= 1'b1;
                        r_state    <= StFin;
                    end else begin
                        r_pend_err <= 1'b0;
                        r_pend_sat <= 1'b0;
                        r_state    <= StMul;
                    end
                end
                StMul: begin
                    r_num   <= w_prod;
                    r_cnt   <= '0;
                    r_state <= StDiv;
                end
                StDiv: begin
                    r_num <= {w_rem_nx, w_quo_nx};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(W - 1)) begin
                        // Quotient never exceeds dx, so the sum stays within x1.
                        r_res   <= r_x0 + w_quo_nx;
                        r_state <= StFin;
                    end
                end
                StFin: begin
                    r_x     <= r_res;
                    r_sat   <= r_pend_sat;
                    r_err   <= r_pend_err;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign x    = r_x;
    assign done = r_done;
    assign busy = r_busy;
    assign sat  = r_sat;
    assign err  = r_err;

endmodule

// File: tb/tb_inverse_interpolate.sv
`timescale 1ns/1ps
// Self-checking bench for inverse_interpolate: a behavioural model predicts
// result, flags and latency; a per-cycle compare process checks done, busy and
// the held outputs.
module tb_inverse_interpolate;

    localparam int unsigned W = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] y, x0, y0, x1, y1;
    logic [W-1:0] x;
    logic         done, busy, sat, err;

    inverse_interpolate #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .y     (y),
        .x0    (x0),
        .y0    (y0),
        .x1    (x1),
        .y1    (y1),
        .x     (x),
        .done  (done),
        .busy  (busy),
        .sat   (sat),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned st;
        int unsigned due;
        int unsigned x;
        bit          sat;
        bit          err;
        int unsigned lat;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int unsigned hold_x = 0;
    bit          hold_sat = 0;
    bit          hold_err = 0;
    bit          exp_done, exp_busy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain arithmetic on the segment definition.
    function automatic exp_t model(input int unsigned ax0, ay0, ax1, ay1, ay);
        exp_t e;
        int unsigned lo, hi, d0, d1;
        longint unsigned num;
        e = '{default: 0};
        lo = (ay0 < ay1) ? ay0 : ay1;
        hi = (ay0 < ay1) ? ay1 : ay0;
        if (ay0 == ay1 || ax1 < ax0) begin
            e.x = ax0; e.err = 1; e.lat = 2;
        end else if (ay < lo || ay > hi) begin
            d0 = (ay > ay0) ? ay - ay0 : ay0 - ay;
            d1 = (ay > ay1) ? ay - ay1 : ay1 - ay;
            e.x = (d0 < d1) ? ax0 : ax1;
            e.sat = 1; e.lat = 2;
        end else begin
            num = longint'((ay1 > ay0) ? ay - ay0 : ay0 - ay) * longint'(ax1 - ax0);
            e.x = ax0 + int'(num / longint'(hi - lo));
            e.lat = W + 3;
        end
        return e;
    endfunction

    // Per-cycle compare against the expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            exp_done = (q.size() > 0) && (cyc == q[0].due);
            exp_busy = (q.size() > 0) && (cyc >= q[0].st) && (cyc < q[0].due);
            if (exp_done) begin
                hold_x   = q[0].x;
                hold_sat = q[0].sat;
                hold_err = q[0].err;
                void'(q.pop_front());
            end
            chk("done", done, exp_done);
            chk("busy", busy, exp_busy);
            chk("x", x, hold_x);
            chk("sat", sat, hold_sat);
            chk("err", err, hold_err);
        end
    end

    task automatic drive(input int unsigned ax0, ay0, ax1, ay1, ay);
        x0 = W'(ax0); y0 = W'(ay0); x1 = W'(ax1); y1 = W'(ay1); y = W'(ay);
    endtask

    // Called at posedge+1 with the DUT idle; start is high for one edge.
    task automatic issue(input int unsigned ax0, ay0, ax1, ay1, ay);
        exp_t e;
        drive(ax0, ay0, ax1, ay1, ay);
        start = 1'b1;
        e = model(ax0, ay0, ax1, ay1, ay);
        e.st = cyc + 1;
        e.due = e.st + e.lat;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() > 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() > 0) begin
            chk("done_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    // Pins the model to hand-computed values, then runs the case on the DUT.
    task automatic directed(input string name, input int unsigned ax0, ay0, ax1, ay1, ay,
                            input int unsigned ex, input bit esat, input bit eerr,
                            input int unsigned elat);
        exp_t m;
        m = model(ax0, ay0, ax1, ay1, ay);
        chk({name, "_model_x"}, m.x, ex);
        chk({name, "_model_sat"}, m.sat, esat);
        chk({name, "_model_err"}, m.err, eerr);
        chk({name, "_model_lat"}, m.lat, elat);
        issue(ax0, ay0, ax1, ay1, ay);
        wait_idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        q.delete();
        hold_x = 0; hold_sat = 0; hold_err = 0;
        @(posedge clk); #1;
        chk("rst_x", x, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sat", sat, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c, rx0, rx1, ry0, ry1, ry, lo, hi, tmp;
        exp_t eb;
        rst = 1'b1;
        start = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        do_reset();

        directed("asc",      100, 200, 300, 600, 400,   200,   0, 0, 17);
        directed("desc",     100, 600, 300, 200, 500,   150,   0, 0, 17);
        directed("trunc",    0,   0,   10,  3,   1,     3,     0, 0, 17);
        directed("clamp_hi", 100, 200, 300, 600, 700,   300,   1, 0, 2);
        directed("clamp_lo", 100, 200, 300, 600, 150,   100,   1, 0, 2);
        directed("degen_y",  7,   50,  9,   50,  50,    7,     0, 1, 2);
        directed("degen_x",  20,  0,   10,  100, 50,    20,    0, 1, 2);
        directed("full",     0,   0,   16383, 16383, 16383, 16383, 0, 0, 17);
        directed("full_one", 0,   0,   16383, 16383, 1, 1,     0, 0, 17);

        // start pulsed every cycle during an operation, with inputs churning.
        drive(100, 200, 300, 600, 523);
        start = 1'b1;
        eb = model(100, 200, 300, 600, 523);
        eb.st = cyc + 1; eb.due = eb.st + eb.lat;
        q.push_back(eb);
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            drive($urandom_range(0, 16383), $urandom_range(0, 16383), $urandom_range(0, 16383),
                  $urandom_range(0, 16383), $urandom_range(0, 16383));
            start = (i % 2 == 0);
        end
        start = 1'b0;
        wait_idle();

        // start held through done: back-to-back with one IDLE cycle.
        c = cyc;
        drive(100, 600, 300, 200, 500);
        start = 1'b1;
        eb = model(100, 600, 300, 200, 500);
        eb.st = c + 1; eb.due = eb.st + eb.lat;
        q.push_back(eb);
        @(posedge clk); #1;
        drive(0, 0, 10, 3, 2);
        eb = model(0, 0, 10, 3, 2);
        eb.st = c + 19; eb.due = eb.st + eb.lat;
        q.push_back(eb);
        while (cyc < c + 19) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_idle();

        // Reset during the eighth divide iteration aborts with no done.
        c = cyc;
        issue(1000, 100, 9000, 12000, 7777);
        while (cyc < c + 11) begin
            @(posedge clk); #1;
        end
        do_reset();
        repeat (20) begin
            @(posedge clk); #1;
        end
        issue(100, 200, 300, 600, 400);
        wait_idle();

        // Randomized segments, mostly in range, with some clamps and degenerates.
        for (int n = 0; n < 80; n++) begin
            rx0 = $urandom_range(0, 16383);
            rx1 = $urandom_range(0, 16383);
            if ($urandom_range(0, 7) != 0 && rx1 < rx0) begin
                tmp = rx0; rx0 = rx1; rx1 = tmp;
            end
            ry0 = $urandom_range(0, 16383);
            ry1 = ($urandom_range(0, 9) == 0) ? ry0 : $urandom_range(0, 16383);
            lo = (ry0 < ry1) ? ry0 : ry1;
            hi = (ry0 < ry1) ? ry1 : ry0;
            ry = ($urandom_range(0, 3) != 0) ? $urandom_range(lo, hi) : $urandom_range(0, 16383);
            issue(rx0, ry0, rx1, ry1, ry);
            wait_idle();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
